universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be an even value of at least 4.
REQ-002 Parameter GROUP, default 4, group size for group-reverse; SHALL divide WIDTH exactly.
REQ-003 Local width AW = $clog2(WIDTH) SHALL size the amount field.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  high when a command can be accepted.
REQ-008 cmd_op  input  3  operation code, encoded per REQ-013.
REQ-009 cmd_amt  input  AW  step count for multi-step ops.
REQ-010 data_in  input  WIDTH  LOAD operand.
REQ-011 ser_in  input  1  serial fill bit for SHL.
REQ-012 q  output  WIDTH  register contents; busy output 1 marks a multi-step op in progress; done output 1 is a one-cycle completion pulse.

Function
REQ-013 Opcodes SHALL be:
- 000 NOP
- 001 LOAD: q <= data_in
- 010 REVERSE: bit i -> bit WIDTH-1-i
- 011 GROUP_REV: reverse the order of GROUP-bit groups; bit order inside each group preserved
- 100 ROTL
- 101 ROTR
- 110 SHL: shift left, ser_in enters bit 0
- 111 ASR: shift right, MSB replicated
REQ-014 Accept: a command is accepted at a rising edge where cmd_valid && cmd_ready.
REQ-015 cmd_ready SHALL equal (state == IDLE); commands presented while busy are ignored and not queued.
REQ-016 FSM states SHALL be IDLE and RUN only.
REQ-017 Single-cycle ops (000–011): q SHALL update at the accept edge, state stays IDLE, and done SHALL be high for exactly the following cycle; NOP leaves q unchanged but still pulses done.
REQ-018 Multi-step ops (100–111) with cmd_amt = k > 0: at the accept edge, latch op and set count = k, go to RUN, busy = 1, q unchanged.
REQ-019 RUN behaviour: on each rising edge, perform one 1-bit step and decrement count; at the edge where count == 1, perform the last step and go to IDLE.
REQ-020 Completion of a multi-step op: busy SHALL fall and done SHALL be high for exactly one cycle after the final step; the final q appears k edges after the accept edge.
REQ-021 Multi-step ops with cmd_amt = 0 SHALL behave as NOP: no RUN entry, q unchanged, done pulse only.
REQ-022 ser_in SHALL be sampled at each SHL step edge, not latched at accept.
REQ-023 data_in, cmd_op and cmd_amt SHALL be ignored while in RUN.
REQ-024 A new command MAY be accepted in the same cycle that done is high.
REQ-025 Rotation SHALL wrap: the bit leaving one end enters the other; k = WIDTH-1 is the largest expressible amount.
REQ-026 done and busy SHALL never be high in the same cycle.

Reset
REQ-027 While rst is high, asynchronously and regardless of clk: q = 0, state = IDLE, count = 0, busy = 0, done = 0, cmd_ready = 1.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first command is acceptable at the first rising edge after rst falls.

Verification (WIDTH=8, GROUP=4 unless stated)
REQ-029 LOAD 0xAA -> q=0xAA after accept edge; done high for one cycle; busy stays 0.
REQ-030 q=0x1E, REVERSE -> q=0x78; q=0xA5, GROUP_REV -> q=0x5A; WIDTH=16: q=0x1234, GROUP_REV -> q=0x4321.
REQ-031 q=0x81, ROTL amt=3 -> busy high for 3 cycles, cmd_ready low during them, q=0x0C after 3rd step, then done pulse; a cmd_valid LOAD during busy leaves q unaffected.
REQ-032 q=0x90, ASR amt=2 -> q=0xE4; q=0x00, SHL amt=4 with ser_in=1,0,1,1 on successive steps -> q=0x0B.
REQ-033 ROTR amt=0 on q=0x3C -> q=0x3C, done pulse, busy never high.
REQ-034 Start ROTR amt=7; assert rst after 2 steps -> q=0x00, busy=0, cmd_ready=1 immediately; no done pulse; LOAD 0x55 accepted on first edge after release.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register with a command handshake.
// Single-cycle ops (NOP/LOAD/REVERSE/GROUP_REV) complete at the accept edge.
// Multi-step ops (ROTL/ROTR/SHL/ASR) then run one 1-bit step per clock
// for cmd_amt cycles. done pulses for one cycle after every completed command.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_amt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam int NG = WIDTH / GROUP;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Opcode encodings
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_REV  = 3'b010;
  localparam logic [2:0] OP_GREV = 3'b011;

  // Low two bits of a multi-step opcode select the step kind
  localparam logic [1:0] ST_ROTL = 2'b00;
  localparam logic [1:0] ST_ROTR = 2'b01;
  localparam logic [1:0] ST_SHL  = 2'b10;
  localparam logic [1:0] ST_ASR  = 2'b11;

  logic [0:0]       r_state;
  logic [AW-1:0]    r_count;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_q;
  logic             r_done;

  logic [WIDTH-1:0] w_reverse;
  logic [WIDTH-1:0] w_group_rev;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_step;

  // Full bit reversal: bit i moves to bit WIDTH-1-i
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign w_reverse[gi] = r_q[WIDTH-1-gi];
  end

  // Group reversal: group g moves to slot NG-1-g, bits inside a group keep order
  for (genvar gi = 0; gi < NG; gi++) begin : g_grev
    assign w_group_rev[gi*GROUP +: GROUP] = r_q[(NG-1-gi)*GROUP +: GROUP];
  end

  // Result of a single-cycle op applied to the current contents
  always_comb begin
    w_single = r_q;
    case (cmd_op)
      OP_NOP:  w_single = r_q;
      OP_LOAD: w_single = data_in;
      OP_REV:  w_single = w_reverse;
      OP_GREV: w_single = w_group_rev;
      default: w_single = r_q;
    endcase
  end

  // One 1-bit step of the latched multi-step op; ser_in is sampled live
  always_comb begin
    w_step = r_q;
    case (r_op)
      ST_ROTL: w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      ST_ROTR: w_step = {r_q[0], r_q[WIDTH-1:1]};
      ST_SHL:  w_step = {r_q[WIDTH-2:0], ser_in};
      ST_ASR:  w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      default: w_step = r_q;
    endcase
  end

  // Command acceptance, RUN stepping and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_op    <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (!cmd_op[2]) begin
              r_q    <= w_single;
              r_done <= 1'b1;
            end else if (cmd_amt == '0) begin
              // Zero-length shift degenerates to a NOP
              r_done <= 1'b1;
            end else begin
              r_op    <= cmd_op[1:0];
              r_count <= cmd_amt;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_q     <= w_step;
          r_count <= r_count - AW'(1);
          if (r_count == AW'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign done      = r_done;
  assign q         = r_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8 main instance, WIDTH=16 for group reverse).
module tb_universal_shift_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_amt;
  logic [7:0]  data_in;
  logic        ser_in;
  logic [7:0]  q;
  logic        busy;
  logic        done;

  logic        c16_valid;
  logic        c16_ready;
  logic [2:0]  c16_op;
  logic [3:0]  c16_amt;
  logic [15:0] c16_data;
  logic [15:0] q16;
  logic        busy16;
  logic        done16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(8), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .data_in(data_in), .ser_in(ser_in),
    .q(q), .busy(busy), .done(done)
  );

  universal_shift_reg #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clk(clk), .rst(rst), .cmd_valid(c16_valid), .cmd_ready(c16_ready),
    .cmd_op(c16_op), .cmd_amt(c16_amt), .data_in(c16_data), .ser_in(1'b0),
    .q(q16), .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one edge, then withdraw it
  task automatic issue(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    data_in   = d;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_amt = '0; data_in = '0; ser_in = 1'b0;
    c16_valid = 1'b0; c16_op = '0; c16_amt = '0; c16_data = '0;
    #2;
    check("rst_q", 16'(q), 16'h00);
    check("rst_ready", 16'(cmd_ready), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    step(); step();
    rst = 1'b0;

    // LOAD
    issue(3'b001, 3'd0, 8'hAA);
    $display("LOAD 0xAA -> q=%h done=%b", q, done);
    check("load_q", 16'(q), 16'hAA);
    check("load_done", 16'(done), 16'h1);
    check("load_busy", 16'(busy), 16'h0);
    step();
    check("load_done_clr", 16'(done), 16'h0);
    check("load_q_hold", 16'(q), 16'hAA);

    // REVERSE (issued back-to-back while done is high)
    issue(3'b001, 3'd0, 8'h1E);
    issue(3'b010, 3'd0, 8'h00);
    $display("REVERSE 0x1E -> q=%h", q);
    check("reverse_q", 16'(q), 16'h78);
    check("reverse_done", 16'(done), 16'h1);

    // GROUP_REV
    issue(3'b001, 3'd0, 8'hA5);
    issue(3'b011, 3'd0, 8'h00);
    $display("GROUP_REV 0xA5 -> q=%h", q);
    check("grev_q", 16'(q), 16'h5A);

    // ROTL by 3 with a LOAD attempted while busy
    issue(3'b001, 3'd0, 8'h81);
    issue(3'b100, 3'd3, 8'h00);
    check("rotl_acc_busy", 16'(busy), 16'h1);
    check("rotl_acc_ready", 16'(cmd_ready), 16'h0);
    check("rotl_acc_q", 16'(q), 16'h81);
    check("rotl_acc_done", 16'(done), 16'h0);
    cmd_valid = 1'b1; cmd_op = 3'b001; data_in = 8'hFF;
    step();
    check("rotl_s1_q", 16'(q), 16'h03);
    check("rotl_s1_busy", 16'(busy), 16'h1);
    check("rotl_s1_ready", 16'(cmd_ready), 16'h0);
    step();
    check("rotl_s2_q", 16'(q), 16'h06);
    check("rotl_s2_busy", 16'(busy), 16'h1);
    cmd_valid = 1'b0;
    step();
    $display("ROTL 0x81 amt=3 -> q=%h busy=%b done=%b", q, busy, done);
    check("rotl_q", 16'(q), 16'h0C);
    check("rotl_busy", 16'(busy), 16'h0);
    check("rotl_done", 16'(done), 16'h1);
    check("rotl_ready", 16'(cmd_ready), 16'h1);
    step();
    check("rotl_done_clr", 16'(done), 16'h0);
    check("rotl_q_hold", 16'(q), 16'h0C);

    // ASR by 2
    issue(3'b001, 3'd0, 8'h90);
    issue(3'b111, 3'd2, 8'h00);
    step(); step();
    $display("ASR 0x90 amt=2 -> q=%h done=%b", q, done);
    check("asr_q", 16'(q), 16'hE4);
    check("asr_done", 16'(done), 16'h1);

    // SHL by 4 with ser_in sampled on each step edge
    issue(3'b001, 3'd0, 8'h00);
    issue(3'b110, 3'd4, 8'h00);
    ser_in = 1'b1; step();
    check("shl_s1_q", 16'(q), 16'h01);
    ser_in = 1'b0; step();
    ser_in = 1'b1; step();
    ser_in = 1'b1; step();
    ser_in = 1'b0;
    $display("SHL amt=4 ser=1011 -> q=%h done=%b", q, done);
    check("shl_q", 16'(q), 16'h0B);
    check("shl_done", 16'(done), 16'h1);

    // ROTR by 0 behaves as NOP
    issue(3'b001, 3'd0, 8'h3C);
    issue(3'b101, 3'd0, 8'h00);
    $display("ROTR 0x3C amt=0 -> q=%h busy=%b done=%b", q, busy, done);
    check("rotr0_q", 16'(q), 16'h3C);
    check("rotr0_busy", 16'(busy), 16'h0);
    check("rotr0_done", 16'(done), 16'h1);
    step();
    check("rotr0_busy2", 16'(busy), 16'h0);
    check("rotr0_done_clr", 16'(done), 16'h0);

    // Reset in the middle of ROTR by 7
    issue(3'b001, 3'd0, 8'h01);
    issue(3'b101, 3'd7, 8'h00);
    step(); step();
    check("rotr7_s2_q", 16'(q), 16'h40);
    check("rotr7_s2_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    #1;
    $display("RST mid-ROTR -> q=%h busy=%b ready=%b done=%b", q, busy, cmd_ready, done);
    check("abort_q", 16'(q), 16'h00);
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_ready", 16'(cmd_ready), 16'h1);
    check("abort_done", 16'(done), 16'h0);
    step();
    check("abort_done_edge", 16'(done), 16'h0);
    rst = 1'b0;
    issue(3'b001, 3'd0, 8'h55);
    $display("LOAD 0x55 after reset -> q=%h", q);
    check("post_rst_q", 16'(q), 16'h55);
    check("post_rst_done", 16'(done), 16'h1);

    // WIDTH=16 group reverse
    c16_valid = 1'b1; c16_op = 3'b001; c16_data = 16'h1234;
    step();
    c16_op = 3'b011; c16_data = 16'h0000;
    step();
    c16_valid = 1'b0;
    $display("GROUP_REV16 0x1234 -> q=%h", q16);
    check("grev16_q", q16, 16'h4321);
    check("grev16_done", 16'(done16), 16'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
